// File: rtl/soc_system_key_debounce.sv
// Per-channel push-button debouncer feeding the key PIO in_port.
// Each channel synchronises its raw key through two flops, then only accepts
// a new level after it has held for DEBOUNCE_CYCLES consecutive cycles.
// Accepted changes also produce one-cycle press/release strobes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// STABLE  | synchronised key equals key_out, counter parked at zero
// COUNT   | synchronised key differs from key_out, qualifying the change
module soc_system_key_debounce #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] busy
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Two-flop synchroniser; resets to the released level so no press is seen at reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= {WIDTH{IDLE_LEVEL}};
      s2 <= {WIDTH{IDLE_LEVEL}};
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;
    logic             rel;
    logic             count_flag;

    // Per-channel qualifier: a single matching sample during COUNT restarts the wait.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state      <= ST_STABLE;
        cnt        <= '0;
        level      <= IDLE_LEVEL;
        press      <= 1'b0;
        rel        <= 1'b0;
        count_flag <= 1'b0;
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        case (state)
          ST_STABLE: begin
            if (s2[i] != level) begin
              state      <= ST_COUNT;
              cnt        <= CNT_ONE;
              count_flag <= 1'b1;
            end
          end
          ST_COUNT: begin
            if (s2[i] == level) begin
              state      <= ST_STABLE;
              cnt        <= '0;
              count_flag <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state      <= ST_STABLE;
              cnt        <= '0;
              count_flag <= 1'b0;
              level      <= s2[i];
              if (s2[i] == IDLE_LEVEL) begin
                rel <= 1'b1;
              end else begin
                press <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state      <= ST_STABLE;
            cnt        <= '0;
            count_flag <= 1'b0;
          end
        endcase
      end
    end

    assign key_out[i]       = level;
    assign press_pulse[i]   = press;
    assign release_pulse[i] = rel;
    assign busy[i]          = count_flag;
  end

endmodule

// File: tb/tb_soc_system_key_debounce.sv
// Bench for soc_system_key_debounce with DEBOUNCE_CYCLES=8, WIDTH=2.
// The reference model accepts a new level when the last D synchronised
// samples all differ from the current debounced level.
module tb_soc_system_key_debounce;

  localparam int   W    = 2;
  localparam int   D    = 8;
  localparam logic IDLE = 1'b1;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] key_in;
  logic [W-1:0] key_out;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;
  logic [W-1:0] busy;

  int checks;
  int errors;
  int pos;
  bit run_cmp;
  int np [W];
  int nr [W];

  soc_system_key_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .IDLE_LEVEL(IDLE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_in(key_in),
    .key_out(key_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sample window of the last D synchronised values per channel.
  logic [W-1:0] m_s1, m_s2, m_ko, m_press, m_rel, m_busy;
  logic [D-1:0] hist [W];
  int           nval [W];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1    = {W{IDLE}};
      m_s2    = {W{IDLE}};
      m_ko    = {W{IDLE}};
      m_press = '0;
      m_rel   = '0;
      m_busy  = '0;
      for (int i = 0; i < W; i++) begin
        hist[i] = '0;
        nval[i] = 0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        logic acc;
        hist[i] = {hist[i][D-2:0], m_s2[i]};
        if (nval[i] < D) nval[i] = nval[i] + 1;
        acc = (nval[i] == D) && (hist[i] == {D{~m_ko[i]}});
        m_busy[i]  = (m_s2[i] != m_ko[i]) && !acc;
        m_press[i] = acc && (m_s2[i] != IDLE);
        m_rel[i]   = acc && (m_s2[i] == IDLE);
        if (acc) m_ko[i] = m_s2[i];
      end
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  end

  // Cycle-by-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model key_out", 32'(key_out), 32'(m_ko));
      chk("model press_pulse", 32'(press_pulse), 32'(m_press));
      chk("model release_pulse", 32'(release_pulse), 32'(m_rel));
      chk("model busy", 32'(busy), 32'(m_busy));
      chk("pulse exclusivity", 32'(press_pulse & release_pulse), 32'd0);
    end
    for (int i = 0; i < W; i++) begin
      np[i] = np[i] + int'(press_pulse[i]);
      nr[i] = nr[i] + int'(release_pulse[i]);
    end
  end

  // Advance to the negedge that follows edge k (edge 0 = first capture after drive).
  task automatic to_edge(input int k);
    while (pos < k) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < W; i++) begin
      np[i] = 0;
      nr[i] = 0;
    end
  endtask

  logic [0:11] pat;

  initial begin
    checks  = 0;
    errors  = 0;
    run_cmp = 1'b0;
    pos     = 0;
    clr_counts();
    reset_n = 1'b0;
    key_in  = 2'b00;
    pat     = 12'b000100000000;

    // 1: reset values, then keys held low through release
    @(posedge clk);
    run_cmp = 1'b1;
    idle_cycles(3);
    chk("reset key_out", 32'(key_out), 32'h3);
    chk("reset press", 32'(press_pulse), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    #1 reset_n = 1'b1;
    pos = -1;
    to_edge(8);
    chk("t1 key_out edge8", 32'(key_out), 32'h3);
    to_edge(9);
    chk("t1 key_out edge9", 32'(key_out), 32'h0);
    chk("t1 press edge9", 32'(press_pulse), 32'h3);
    to_edge(10);
    chk("t1 press edge10", 32'(press_pulse), 32'h0);
    idle_cycles(2);

    // 5: simultaneous release of both keys
    key_in = 2'b11;
    pos = -1;
    to_edge(8);
    chk("t5 release edge8", 32'(release_pulse), 32'h0);
    to_edge(9);
    chk("t5 release edge9", 32'(release_pulse), 32'h3);
    chk("t5 key_out edge9", 32'(key_out), 32'h3);
    to_edge(10);
    chk("t5 release edge10", 32'(release_pulse), 32'h0);
    idle_cycles(2);

    // 2: clean press on channel 0
    key_in = 2'b10;
    pos = -1;
    to_edge(1);
    chk("t2 busy edge1", 32'(busy), 32'h0);
    to_edge(2);
    chk("t2 busy edge2", 32'(busy), 32'h1);
    to_edge(8);
    chk("t2 key_out edge8", 32'(key_out), 32'h3);
    to_edge(9);
    chk("t2 key_out edge9", 32'(key_out), 32'h2);
    chk("t2 press edge9", 32'(press_pulse), 32'h1);
    to_edge(10);
    chk("t2 press edge10", 32'(press_pulse), 32'h0);
    key_in = 2'b11;
    idle_cycles(12);
    chk("t2 released", 32'(key_out), 32'h3);

    // 3: single-cycle bounce restarts qualification
    clr_counts();
    pos = -1;
    for (int j = 0; j < 12; j++) begin
      key_in[0] = pat[j];
      @(negedge clk);
      pos++;
    end
    chk("t3 key_out edge11", 32'(key_out[0]), 32'h1);
    to_edge(12);
    chk("t3 key_out edge12", 32'(key_out[0]), 32'h1);
    to_edge(13);
    chk("t3 key_out edge13", 32'(key_out[0]), 32'h0);
    chk("t3 press edge13", 32'(press_pulse[0]), 32'h1);
    idle_cycles(10);
    chk("t3 press count", 32'(np[0]), 32'd1);
    key_in = 2'b11;
    idle_cycles(12);

    // 4: seven-cycle glitch on channel 1 is rejected
    clr_counts();
    key_in[1] = 1'b0;
    pos = -1;
    to_edge(6);
    key_in[1] = 1'b1;
    to_edge(4);
    idle_cycles(12);
    chk("t4 key_out1", 32'(key_out[1]), 32'h1);
    chk("t4 busy1", 32'(busy[1]), 32'h0);
    chk("t4 pulses1", 32'(np[1] + nr[1]), 32'd0);

    // 6: reset while counting, key still held low
    clr_counts();
    key_in = 2'b10;
    pos = -1;
    to_edge(6);
    chk("t6 busy before reset", 32'(busy), 32'h1);
    #1 reset_n = 1'b0;
    #2;
    chk("t6 key_out in reset", 32'(key_out), 32'h3);
    chk("t6 busy in reset", 32'(busy), 32'h0);
    @(negedge clk);
    chk("t6 press in reset", 32'(press_pulse), 32'h0);
    #1 reset_n = 1'b1;
    pos = -1;
    to_edge(8);
    chk("t6 press edge8", 32'(press_pulse), 32'h0);
    chk("t6 key_out edge8", 32'(key_out), 32'h3);
    to_edge(9);
    chk("t6 press edge9", 32'(press_pulse), 32'h1);
    chk("t6 key_out edge9", 32'(key_out), 32'h2);
    to_edge(10);
    chk("t6 press count", 32'(np[0]), 32'd1);
    key_in = 2'b11;
    idle_cycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
